// File: rtl/kmeans_iter_sched_if.sv
// Host control and stage handshake bundle for the k-means iteration scheduler.
// The master modport is the scheduler side; the slave modport is host plus datapath.
interface kmeans_iter_sched_if #(
    parameter int ITER_W = 16
);
    logic              start_i;
    logic              abort_i;
    logic [ITER_W-1:0] max_iters_i;
    logic              ready_o;
    logic              done_o;
    logic              converged_o;
    logic              timeout_o;
    logic              aborted_o;
    logic [ITER_W-1:0] iter_count_o;
    logic [1:0]        active_stage_o;
    logic              dc_start_o;
    logic              fcc_start_o;
    logic              cu_start_o;
    logic              dc_ready_i;
    logic              fcc_ready_i;
    logic              cu_ready_i;
    logic [31:0]       cu_changed_i;

    modport master (
        input  start_i, abort_i, max_iters_i,
        input  dc_ready_i, fcc_ready_i, cu_ready_i, cu_changed_i,
        output ready_o, done_o, converged_o, timeout_o, aborted_o,
        output iter_count_o, active_stage_o,
        output dc_start_o, fcc_start_o, cu_start_o
    );

    modport slave (
        output start_i, abort_i, max_iters_i,
        output dc_ready_i, fcc_ready_i, cu_ready_i, cu_changed_i,
        input  ready_o, done_o, converged_o, timeout_o, aborted_o,
        input  iter_count_o, active_stage_o,
        input  dc_start_o, fcc_start_o, cu_start_o
    );
endinterface

// File: rtl/kmeans_iter_sched.sv
// Iteration scheduler: runs DC -> FCC -> CU per iteration until the run converges,
// hits the iteration limit, is aborted at a stage boundary, or a stage times out.
module kmeans_iter_sched #(
    parameter int ITER_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk_i,
    input logic               reset_i,
    kmeans_iter_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_EVAL, S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0, ST_DC = 2'd1, ST_FCC = 2'd2, ST_CU = 2'd3
    } stage_e;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [ITER_W-1:0] ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    stage_e            stage_q, stage_d;
    logic [ITER_W-1:0] limit_q, limit_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [31:0]       changed_q, changed_d;
    logic [31:0]       tcnt_q, tcnt_d;
    logic              abort_pend_q, abort_pend_d;
    logic              conv_q, conv_d;
    logic              tmo_q, tmo_d;
    logic              abrt_q, abrt_d;
    logic              sel_ready;
    logic [ITER_W-1:0] iter_inc;

    always_comb begin
        sel_ready = 1'b1;
        unique case (stage_q)
            ST_DC:   sel_ready = bus.dc_ready_i;
            ST_FCC:  sel_ready = bus.fcc_ready_i;
            ST_CU:   sel_ready = bus.cu_ready_i;
            default: sel_ready = 1'b1;
        endcase
    end

    assign iter_inc = iter_q + ONE;

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        limit_d      = limit_q;
        iter_d       = iter_q;
        changed_d    = changed_q;
        tcnt_d       = tcnt_q;
        conv_d       = conv_q;
        tmo_d        = tmo_q;
        abrt_d       = abrt_q;
        abort_pend_d = abort_pend_q | ((state_q != S_IDLE) & bus.abort_i);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    limit_d = (bus.max_iters_i == '0) ? ONE : bus.max_iters_i;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    tmo_d   = 1'b0;
                    abrt_d  = 1'b0;
                    stage_d = ST_DC;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tcnt_d  = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tcnt_d = tcnt_q + 32'd1;
                if (tcnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (!sel_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                tcnt_d = tcnt_q + 32'd1;
                // A timeout wins over a completion seen in the same cycle.
                if (tcnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (sel_ready) begin
                    unique case (stage_q)
                        ST_CU: begin
                            changed_d = bus.cu_changed_i;
                            state_d   = S_EVAL;
                        end
                        ST_DC, ST_FCC: begin
                            if (abort_pend_q) begin
                                abrt_d  = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                stage_d = (stage_q == ST_DC) ? ST_FCC : ST_CU;
                                state_d = S_LAUNCH;
                            end
                        end
                        default: state_d = S_FINISH;
                    endcase
                end
            end
            S_EVAL: begin
                iter_d = iter_inc;
                if (changed_q == 32'd0) begin
                    conv_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (abort_pend_q) begin
                    abrt_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (iter_inc >= limit_q) begin
                    state_d = S_FINISH;
                end else begin
                    stage_d = ST_DC;
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: begin
                stage_d      = ST_NONE;
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            stage_q      <= ST_NONE;
            limit_q      <= ONE;
            iter_q       <= '0;
            changed_q    <= '0;
            tcnt_q       <= '0;
            abort_pend_q <= 1'b0;
            conv_q       <= 1'b0;
            tmo_q        <= 1'b0;
            abrt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            limit_q      <= limit_d;
            iter_q       <= iter_d;
            changed_q    <= changed_d;
            tcnt_q       <= tcnt_d;
            abort_pend_q <= abort_pend_d;
            conv_q       <= conv_d;
            tmo_q        <= tmo_d;
            abrt_q       <= abrt_d;
        end
    end

    logic in_stage;
    assign in_stage = (state_q == S_LAUNCH) || (state_q == S_WAIT_ACK) ||
                      (state_q == S_WAIT_DONE);

    assign bus.ready_o        = (state_q == S_IDLE);
    assign bus.done_o         = (state_q == S_FINISH);
    assign bus.converged_o    = conv_q;
    assign bus.timeout_o      = tmo_q;
    assign bus.aborted_o      = abrt_q;
    assign bus.iter_count_o   = iter_q;
    assign bus.active_stage_o = in_stage ? stage_q : ST_NONE;
    assign bus.dc_start_o     = (state_q == S_LAUNCH) && (stage_q == ST_DC);
    assign bus.fcc_start_o    = (state_q == S_LAUNCH) && (stage_q == ST_FCC);
    assign bus.cu_start_o     = (state_q == S_LAUNCH) && (stage_q == ST_CU);
endmodule

// File: tb/tb_kmeans_iter_sched.sv
// Directed bench for kmeans_iter_sched with behavioural DC/FCC/CU stubs,
// each busy five cycles after its start pulse.
module tb_kmeans_iter_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kmeans_iter_sched_if #(.ITER_W(16)) bus ();

    kmeans_iter_sched #(.ITER_W(16), .TIMEOUT_CYCLES(50)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.master)
    );

    logic [7:0]  dc_busy, fcc_busy, cu_busy;
    logic        dc_hang = 1'b0;
    logic [31:0] cu_val;
    int          cu_seen;
    logic [31:0] chg0 = 0, chg1 = 0, chg2 = 0, chg_def = 0;

    assign bus.dc_ready_i   = (dc_busy == 0);
    assign bus.fcc_ready_i  = (fcc_busy == 0);
    assign bus.cu_ready_i   = (cu_busy == 0);
    assign bus.cu_changed_i = cu_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_busy  <= 0;
            fcc_busy <= 0;
            cu_busy  <= 0;
            cu_val   <= 0;
            cu_seen  <= 0;
        end else begin
            if (bus.dc_start_o) dc_busy <= 5;
            else if (dc_busy != 0 && !dc_hang) dc_busy <= dc_busy - 1;
            if (bus.fcc_start_o) fcc_busy <= 5;
            else if (fcc_busy != 0) fcc_busy <= fcc_busy - 1;
            if (bus.cu_start_o) begin
                cu_busy <= 5;
                cu_val  <= (cu_seen == 0) ? chg0 : (cu_seen == 1) ? chg1 :
                           (cu_seen == 2) ? chg2 : chg_def;
                cu_seen <= cu_seen + 1;
            end else if (cu_busy != 0) begin
                cu_busy <= cu_busy - 1;
            end
            if (bus.start_i && bus.ready_o) cu_seen <= 0;
        end
    end

    // Per-run event log, cleared when a start is accepted.
    int          dc_cnt = 0, fcc_cnt = 0, cu_cnt = 0, done_cnt = 0;
    logic [31:0] seq = 0;

    always @(posedge clk) begin
        if (bus.start_i && bus.ready_o) begin
            dc_cnt <= 0; fcc_cnt <= 0; cu_cnt <= 0; done_cnt <= 0; seq <= 0;
        end else begin
            if (bus.dc_start_o) begin
                dc_cnt <= dc_cnt + 1; seq <= {seq[29:0], 2'd1};
            end
            if (bus.fcc_start_o) begin
                fcc_cnt <= fcc_cnt + 1; seq <= {seq[29:0], 2'd2};
            end
            if (bus.cu_start_o) begin
                cu_cnt <= cu_cnt + 1; seq <= {seq[29:0], 2'd3};
            end
            if (bus.done_o) done_cnt <= done_cnt + 1;
        end
    end

    task automatic run_start(input logic [15:0] lim);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.max_iters_i = lim;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!bus.done_o && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.done_o !== 1'b1) begin
            $display("FAIL wait_done: done_o=%b after %0d cycles, required 1", bus.done_o, cyc);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            $display("FAIL reset_rdy_done: ready=%b done=%b, required 1 0", bus.ready_o, bus.done_o);
            errors++;
        end
        checks++;
        if ({bus.dc_start_o, bus.fcc_start_o, bus.cu_start_o} !== 3'b000) begin
            $display("FAIL reset_starts: %b, required 000",
                     {bus.dc_start_o, bus.fcc_start_o, bus.cu_start_o});
            errors++;
        end
        checks++;
        if ({bus.converged_o, bus.timeout_o, bus.aborted_o} !== 3'b000) begin
            $display("FAIL reset_flags: %b, required 000",
                     {bus.converged_o, bus.timeout_o, bus.aborted_o});
            errors++;
        end
        checks++;
        if (bus.iter_count_o !== 16'd0 || bus.active_stage_o !== 2'd0) begin
            $display("FAIL reset_cnt_stage: iter=%0d stage=%0d, required 0 0",
                     bus.iter_count_o, bus.active_stage_o);
            errors++;
        end
    endtask

    task automatic test_converge();
        int cyc;
        logic [31:0] exp_seq;
        chg0 = 7; chg1 = 2; chg2 = 0; chg_def = 9;
        run_start(16'd10);
        checks++;
        if (bus.dc_start_o !== 1'b1 || bus.active_stage_o !== 2'd1 || bus.ready_o !== 1'b0) begin
            $display("FAIL conv_launch: dc_start=%b stage=%0d ready=%b, required 1 1 0",
                     bus.dc_start_o, bus.active_stage_o, bus.ready_o);
            errors++;
        end
        wait_done(400, cyc);
        exp_seq = 0;
        for (int i = 0; i < 3; i++) exp_seq = {exp_seq[25:0], 6'b01_10_11};
        checks++;
        if (seq !== exp_seq || dc_cnt + fcc_cnt + cu_cnt != 9) begin
            $display("FAIL conv_seq: seq=%h starts=%0d, required %h 9",
                     seq, dc_cnt + fcc_cnt + cu_cnt, exp_seq);
            errors++;
        end
        checks++;
        if (bus.converged_o !== 1'b1 || bus.iter_count_o !== 16'd3) begin
            $display("FAIL conv_status: conv=%b iter=%0d, required 1 3",
                     bus.converged_o, bus.iter_count_o);
            errors++;
        end
        checks++;
        if (done_cnt != 1 || bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            $display("FAIL conv_done: pulses=%0d ready=%b done=%b, required 1 1 0",
                     done_cnt, bus.ready_o, bus.done_o);
            errors++;
        end
    endtask

    task automatic test_limit();
        int cyc;
        chg0 = 4; chg1 = 4; chg2 = 4; chg_def = 4;
        run_start(16'd2);
        wait_done(400, cyc);
        checks++;
        if (bus.converged_o !== 1'b0 || bus.iter_count_o !== 16'd2 || cu_cnt != 2) begin
            $display("FAIL limit: conv=%b iter=%0d cu=%0d, required 0 2 2",
                     bus.converged_o, bus.iter_count_o, cu_cnt);
            errors++;
        end
    endtask

    task automatic test_zero_limit();
        int cyc;
        chg0 = 5; chg1 = 5; chg2 = 5; chg_def = 5;
        run_start(16'd0);
        wait_done(400, cyc);
        checks++;
        if (bus.converged_o !== 1'b0 || bus.iter_count_o !== 16'd1 || cu_cnt != 1) begin
            $display("FAIL zero_limit: conv=%b iter=%0d cu=%0d, required 0 1 1",
                     bus.converged_o, bus.iter_count_o, cu_cnt);
            errors++;
        end
    endtask

    task automatic test_abort();
        int cyc;
        int n;
        chg0 = 4; chg1 = 4; chg2 = 4; chg_def = 4;
        run_start(16'd10);
        n = 0;
        while (fcc_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        wait_done(400, cyc);
        checks++;
        if (cu_cnt != 0 || fcc_cnt != 1 || bus.aborted_o !== 1'b1) begin
            $display("FAIL abort: cu=%0d fcc=%0d aborted=%b, required 0 1 1",
                     cu_cnt, fcc_cnt, bus.aborted_o);
            errors++;
        end
        checks++;
        if (bus.iter_count_o !== 16'd0 || bus.converged_o !== 1'b0) begin
            $display("FAIL abort_status: iter=%0d conv=%b, required 0 0",
                     bus.iter_count_o, bus.converged_o);
            errors++;
        end
        run_start(16'd1);
        wait_done(400, cyc);
        checks++;
        if (bus.aborted_o !== 1'b0 || bus.iter_count_o !== 16'd1 || cu_cnt != 1) begin
            $display("FAIL abort_rerun: aborted=%b iter=%0d cu=%0d, required 0 1 1",
                     bus.aborted_o, bus.iter_count_o, cu_cnt);
            errors++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        dc_hang = 1'b1;
        run_start(16'd5);
        // cyc counts negedges from the LAUNCH cycle; WAIT_ACK is entered at 1.
        wait_done(200, cyc);
        checks++;
        if (cyc != 51) begin
            $display("FAIL timeout_lat: done at %0d cycles after launch, required 51", cyc);
            errors++;
        end
        checks++;
        if (bus.timeout_o !== 1'b1 || fcc_cnt != 0 || bus.ready_o !== 1'b1) begin
            $display("FAIL timeout_status: tmo=%b fcc=%0d ready=%b, required 1 0 1",
                     bus.timeout_o, fcc_cnt, bus.ready_o);
            errors++;
        end
        dc_hang = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int n;
        chg0 = 4; chg1 = 4; chg2 = 4; chg_def = 4;
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.max_iters_i = 16'd10;
        n = 0;
        while (cu_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (dc_cnt != 2 || bus.iter_count_o !== 16'd1 || bus.ready_o !== 1'b0 ||
            bus.active_stage_o !== 2'd3) begin
            $display("FAIL hold_start: dc=%0d iter=%0d ready=%b stage=%0d, required 2 1 0 3",
                     dc_cnt, bus.iter_count_o, bus.ready_o, bus.active_stage_o);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.iter_count_o !== 16'd0 ||
            bus.active_stage_o !== 2'd0 || bus.done_o !== 1'b0) begin
            $display("FAIL async_reset: ready=%b iter=%0d stage=%0d done=%b, required 1 0 0 0",
                     bus.ready_o, bus.iter_count_o, bus.active_stage_o, bus.done_o);
            errors++;
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 0 || bus.ready_o !== 1'b1) begin
            $display("FAIL reset_no_done: pulses=%0d ready=%b, required 0 1",
                     done_cnt, bus.ready_o);
            errors++;
        end
        chg0 = 0;
        run_start(16'd3);
        wait_done(400, cyc);
        checks++;
        if (bus.converged_o !== 1'b1 || bus.iter_count_o !== 16'd1 || seq !== 32'h1B) begin
            $display("FAIL fresh_run: conv=%b iter=%0d seq=%h, required 1 1 0000001b",
                     bus.converged_o, bus.iter_count_o, seq);
            errors++;
        end
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.max_iters_i = 16'd0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_converge();
        test_limit();
        test_zero_limit();
        test_abort();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
